// File: rtl/onehot_scan_decoder_if.sv
// Handshake/bus bundle for the one-hot scan decoder: control and index
// inputs towards the decoder, registered decode outputs back.
interface onehot_scan_decoder_if #(
  parameter int W = 3,
  parameter int N = 2**W
);
  logic         clr;
  logic         mode;
  logic         load;
  logic         en;
  logic         dir;
  logic [W-1:0] inp;
  logic [N-1:0] out;
  logic         valid;
  logic         wrap;

  modport master (
    output clr, mode, load, en, dir, inp,
    input  out, valid, wrap
  );

  modport slave (
    input  clr, mode, load, en, dir, inp,
    output out, valid, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with a scan mode that steps the
// index up or down and flags wrap-around. All outputs come straight from
// flops; the next-state logic below also precomputes the next output word.
module onehot_scan_decoder #(
  parameter int W       = 3,
  parameter int N       = 2**W,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_scan_decoder_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t       state, nstate;
  logic [W-1:0] idx, nidx;
  logic         nwrap;
  logic [N-1:0] dec;

  localparam logic [W-1:0] IDX_MAX = {W{1'b1}};

  // Next state/index with priority clr > load > en; rst is handled in the flop.
  always_comb begin
    nstate = state;
    nidx   = idx;
    nwrap  = 1'b0;
    if (bus.clr) begin
      nstate = IDLE;
    end else if (bus.load) begin
      nidx   = bus.inp;
      nstate = ACTIVE;
    end else if (bus.en) begin
      if (!bus.mode) begin
        nidx   = bus.inp;
        nstate = ACTIVE;
      end else if (state == IDLE) begin
        // First scan enable only wakes the decoder; stepping begins next en.
        nstate = ACTIVE;
      end else if (bus.dir) begin
        nidx  = idx - 1'b1;
        nwrap = (idx == '0);
      end else begin
        nidx  = idx + 1'b1;
        nwrap = (idx == IDX_MAX);
      end
    end
  end

  // Decode the next index so out lines up with valid in the same cycle.
  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) dec[i] = (nidx == W'(i));
  end

  // State, index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      bus.valid <= 1'b0;
      bus.wrap  <= 1'b0;
      bus.out   <= {N{ACT_LOW}};
    end else begin
      state     <= nstate;
      idx       <= nidx;
      bus.valid <= (nstate == ACTIVE);
      bus.wrap  <= nwrap;
      bus.out   <= (nstate == ACTIVE) ? (dec ^ {N{ACT_LOW}}) : {N{ACT_LOW}};
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench: each driven cycle pushes the expected post-edge outputs
// from a behavioural model; a monitor pops and compares after every edge.
// A second instance with ACT_LOW=1 shares the stimulus and must show the
// bitwise complement of the active-high decode.
module tb_onehot_scan_decoder;
  localparam int W = 3;
  localparam int N = 2**W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.W(W), .N(N)) bh ();
  onehot_scan_decoder_if #(.W(W), .N(N)) bl ();

  onehot_scan_decoder #(.W(W), .N(N), .ACT_LOW(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(bh.slave));
  onehot_scan_decoder #(.W(W), .N(N), .ACT_LOW(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(bl.slave));

  typedef struct {
    logic [N-1:0] out;
    logic         valid;
    logic         wrap;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: current index as an integer and an "active" flag.
  int m_idx    = 0;
  bit m_active = 0;
  bit m_wrap   = 0;

  task automatic model(input bit r, c, md, ld, e, d, input int in_v);
    m_wrap = 0;
    if (r) begin
      m_idx = 0; m_active = 0;
    end else if (c) begin
      m_active = 0;
    end else if (ld) begin
      m_idx = in_v; m_active = 1;
    end else if (e) begin
      if (!md) begin
        m_idx = in_v; m_active = 1;
      end else if (!m_active) begin
        m_active = 1;
      end else if (d) begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + N - 1) % N;
      end else begin
        m_wrap = (m_idx == N - 1);
        m_idx  = (m_idx + 1) % N;
      end
    end
  endtask

  // Drive one cycle of stimulus (away from the rising edge) and queue the expectation.
  task automatic drive(input bit r, c, md, ld, e, d, input int in_v);
    exp_t x;
    @(negedge clk);
    rst = r;
    bh.clr = c; bh.mode = md; bh.load = ld; bh.en = e; bh.dir = d; bh.inp = W'(in_v);
    bl.clr = c; bl.mode = md; bl.load = ld; bl.en = e; bl.dir = d; bl.inp = W'(in_v);
    model(r, c, md, ld, e, d, in_v);
    x.valid = m_active;
    x.wrap  = m_wrap;
    x.out   = m_active ? N'(1 << m_idx) : '0;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are registered, so compare once per edge, 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk("out",       bh.out,   x.out);
      chk("valid",     N'(bh.valid), N'(x.valid));
      chk("wrap",      N'(bh.wrap),  N'(x.wrap));
      chk("out_low",   bl.out,   ~x.out);
      chk("valid_low", N'(bl.valid), N'(x.valid));
      chk("wrap_low",  N'(bl.wrap),  N'(x.wrap));
    end
  end

  initial begin
    rst = 1'b1;
    bh.clr = 0; bh.mode = 0; bh.load = 0; bh.en = 0; bh.dir = 0; bh.inp = '0;
    bl.clr = 0; bl.mode = 0; bl.load = 0; bl.en = 0; bl.dir = 0; bl.inp = '0;

    // Reset held, then idle with nothing asserted.
    drive(1,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0);

    // Direct sweep 0..7, including inp=3 for the active-low instance.
    for (int i = 0; i < N; i++) drive(0,0,0,0,1,0,i);
    drive(0,0,0,0,0,1,2);                       // hold; dir ignored

    // Scan up with wrap from 6.
    drive(0,0,0,1,0,0,6);
    for (int i = 0; i < 3; i++) drive(0,0,1,0,1,0,0);

    // Scan down with wrap from 1.
    drive(0,0,0,1,0,0,1);
    for (int i = 0; i < 2; i++) drive(0,0,1,0,1,1,0);

    // Priority: load beats en at idx=2; clr beats load.
    drive(0,0,0,1,0,0,2);
    drive(0,0,1,1,1,0,5);
    drive(0,1,1,1,1,0,7);
    drive(0,0,1,0,1,0,0);                       // wake from IDLE, idx kept
    drive(0,0,1,0,1,0,0);                       // first step

    // Reset mid-scan at idx=4, then wake in scan mode.
    drive(0,0,0,1,0,0,4);
    drive(1,0,1,1,1,0,6);
    drive(0,0,1,0,1,0,0);
    drive(0,0,1,0,0,0,0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0,39) == 0), ($urandom_range(0,7) == 0),
            1'($urandom), ($urandom_range(0,5) == 0), 1'($urandom),
            1'($urandom), int'($urandom_range(0,N-1)));
    end
    drive(0,0,0,0,0,0,0);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onehot_scan_decoder.md
ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 SHALL have parameter W, default 3, binary index width.
REQ-002 SHALL have parameter N, default 2**W, one-hot output width; values other than 2**W unsupported.
REQ-003 SHALL have parameter ACT_LOW, default 0; 1 inverts every bit of out.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  return to IDLE, out cleared.
REQ-007 SHALL have port mode  input  1  0 = direct decode, 1 = scan.
REQ-008 SHALL have port load  input  1  capture inp into index register.
REQ-009 SHALL have port en  input  1  direct: capture inp; scan: step index.
REQ-010 SHALL have port dir  input  1  scan direction: 0 = up, 1 = down.
REQ-011 SHALL have port inp  input  W  binary index.
REQ-012 SHALL have port out  output  N  registered one-hot (one-cold if ACT_LOW).
REQ-013 SHALL have port valid  output  1  out holds a decoded index.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-015 SHALL hold internal index register idx[W-1:0] and a two-state FSM, IDLE and ACTIVE.
REQ-016 SHALL drive all outputs from registers only, with no combinational path from inputs to outputs.
REQ-017 SHALL, in IDLE, drive valid=0, wrap=0, and out all-inactive (0s, or 1s if ACT_LOW).
REQ-018 SHALL, in ACTIVE, drive valid=1 and out with exactly bit idx active, all other bits inactive.
REQ-019 SHALL apply per-edge priority rst > clr > load > en.
REQ-020 SHALL, on clr=1, go to IDLE, leave idx unchanged, and drive wrap=0 next cycle.
REQ-021 SHALL, on load=1 in either mode or state, set idx<=inp and go to ACTIVE; en that same cycle is ignored.
REQ-022 SHALL, in direct mode (mode=0) with en=1 and load=0, set idx<=inp and go to ACTIVE; latency inp->out is 1 cycle.
REQ-023 SHALL, in scan mode (mode=1) with en=1, load=0 and state ACTIVE, set idx<=idx+1 mod 2**W (dir=0) or idx<=idx-1 mod 2**W (dir=1).
REQ-024 SHALL, in scan mode with en=1 while IDLE, go to ACTIVE without changing idx; stepping starts on the following en.
REQ-025 SHALL assert wrap for exactly the cycle after a step from 2**W-1 to 0 (up) or 0 to 2**W-1 (down); wrap=0 at all other times.
REQ-026 SHALL hold idx, state and out unchanged when clr, load and en are all 0.
REQ-027 SHALL take effect on a mode change at the next edge only; idx is preserved across mode changes.
REQ-028 SHALL ignore dir in direct mode.
REQ-029 SHALL ensure out never has more than one active bit in any cycle.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set idx=0, state=IDLE, valid=0, wrap=0, out all-inactive.
REQ-031 SHALL let rst override clr, load and en in the same cycle, and abort any scan in progress.
REQ-032 SHALL keep all outputs at reset values while rst is held high.

Verification (W=3, ACT_LOW=0 unless stated)
REQ-033 SHALL cover direct sweep: mode=0, en=1, inp=0..7 on successive cycles -> out=00000001..10000000, each one cycle after its inp, valid=1 throughout.
REQ-034 SHALL cover scan up with wrap: load inp=6, then mode=1, en=1 for 3 cycles, dir=0 -> out=01000000, 10000000, 00000001, 00000010; wrap=1 only with 00000001.
REQ-035 SHALL cover scan down with wrap: load inp=1, mode=1, en=1, dir=1 for 2 cycles -> out=00000001 then 10000000 with wrap=1.
REQ-036 SHALL cover priority: load=1, en=1, inp=5 in scan mode at idx=2 -> out=00100000, no step; then clr=1 with load=1 -> valid=0, out=00000000.
REQ-037 SHALL cover reset mid-scan: rst=1 during an active scan at idx=4 -> next cycle out=00000000, valid=0, wrap=0; after release, mode=1, en=1 -> valid=1, out=00000001.
REQ-038 SHALL cover ACT_LOW=1: direct decode inp=3 -> out=11110111; IDLE -> out=11111111.
